// File: rtl/udsp_frame_io.sv
// Frame sequencer for the uDSP core: load input samples into data memory,
// run the core for a fixed budget, then stream the output segment back out.
module udsp_frame_io #(
  parameter int DAW         = 10,
  parameter int DWW         = 36,
  parameter int SW          = 24,
  parameter int NUM_IN      = 8,
  parameter int NUM_OUT     = 8,
  parameter int IN_BASE     = 0,
  parameter int OUT_BASE    = 128,
  parameter int PROG_CYCLES = 516
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [SW-1:0]  in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [SW-1:0]  out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           dsp_start,
  output logic [DAW-1:0] io_addrW,
  output logic [DWW-1:0] io_dataW,
  output logic           io_writeEn,
  output logic [DAW-1:0] io_addrR,
  input  logic [DWW-1:0] io_dataR,
  output logic [15:0]    frame_count
);
  localparam int CW  = DAW + 1;
  localparam int RCW = $clog2(PROG_CYCLES + 1);

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  in_k, rd_k, out_k;
  logic [RCW-1:0] run_cnt;
  logic           load_done, first_rd, rd_pend;
  logic [DAW-1:0] addr_q, rd_addr;
  logic [SW-1:0]  out_q;
  logic           hs_in, hs_out, in_last, out_last, rd_issue;
  logic           unused_low;

  assign hs_in    = (state_q == LOAD) && in_valid && in_ready;
  assign hs_out   = (state_q == DRAIN) && out_valid && out_ready;
  assign in_last  = (in_k == CW'(NUM_IN - 1));
  assign out_last = (out_k == CW'(NUM_OUT - 1));
  // First read fires on DRAIN entry; later reads ride on each output handshake.
  assign rd_issue = (state_q == DRAIN) && (first_rd || (hs_out && !out_last));
  assign rd_addr  = DAW'(OUT_BASE) + rd_k[DAW-1:0];
  assign io_addrR = rd_issue ? rd_addr : addr_q;
  assign dsp_start = (state_q != RUN);
  // Fresh RAM data is passed through; a stalled sample is replayed from out_q.
  assign out_data = rd_pend ? io_dataR[DWW-1 -: SW] : out_q;
  assign unused_low = ^io_dataR[DWW-SW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done) state_d = RUN;
      RUN:     if (run_cnt == RCW'(PROG_CYCLES - 1)) state_d = DRAIN;
      DRAIN:   if (hs_out && out_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      in_ready    <= 1'b0;
      load_done   <= 1'b0;
      in_k        <= '0;
      io_writeEn  <= 1'b0;
      io_addrW    <= '0;
      io_dataW    <= '0;
      run_cnt     <= '0;
      first_rd    <= 1'b0;
      rd_pend     <= 1'b0;
      rd_k        <= '0;
      out_k       <= '0;
      addr_q      <= '0;
      out_q       <= '0;
      out_valid   <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q   <= state_d;
      // The final write lands in an extra LOAD cycle so it commits before the core runs.
      load_done <= hs_in && in_last;
      in_ready  <= (state_d == LOAD) && !(hs_in && in_last);

      io_writeEn <= hs_in;
      if (hs_in) begin
        io_addrW <= DAW'(IN_BASE) + in_k[DAW-1:0];
        io_dataW <= {in_data, {(DWW-SW){1'b0}}};
        in_k     <= in_last ? '0 : in_k + 1'b1;
      end

      run_cnt  <= (state_q == RUN) ? run_cnt + 1'b1 : '0;
      first_rd <= (state_q == RUN) && (state_d == DRAIN);
      rd_pend  <= rd_issue;

      if (rd_issue) addr_q <= rd_addr;
      if (hs_out && out_last) rd_k <= '0;
      else if (rd_issue)      rd_k <= rd_k + 1'b1;
      if (rd_pend) out_q <= io_dataR[DWW-1 -: SW];

      out_valid <= rd_issue || (out_valid && !hs_out);
      if (hs_out) out_k <= out_last ? '0 : out_k + 1'b1;
      if (hs_out && out_last) frame_count <= frame_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_udsp_frame_io.sv
// Directed bench for udsp_frame_io with a registered data-memory model.
module tb_udsp_frame_io;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        dsp_start;
  logic [9:0]  io_addrW;
  logic [35:0] io_dataW;
  logic        io_writeEn;
  logic [9:0]  io_addrR;
  logic [35:0] io_dataR;
  logic [15:0] frame_count;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [35:0] pl_data;
  logic [35:0] mem [0:1023];

  int nvec = 0, nfail = 0;
  int span;

  logic [35:0] v1 [8] = '{36'h800000FFF, 36'h7FFFFF000, 36'h123456ABC, 36'hFEDCBA001,
                          36'h000001FFF, 36'hFFFFFF000, 36'h400000800, 36'hC00000000};
  logic [23:0] e1 [8] = '{24'h800000, 24'h7FFFFF, 24'h123456, 24'hFEDCBA,
                          24'h000001, 24'hFFFFFF, 24'h400000, 24'hC00000};
  logic [35:0] v2 [8] = '{36'h0ABCDE123, 36'hF00001FFF, 36'h555555AAA, 36'hAAAAAA555,
                          36'h000000FFF, 36'h800001000, 36'h3C3C3C000, 36'hFFFFFEFFF};
  logic [23:0] e2 [8] = '{24'h0ABCDE, 24'hF00001, 24'h555555, 24'hAAAAAA,
                          24'h000000, 24'h800001, 24'h3C3C3C, 24'hFFFFFE};

  always #5 clk = ~clk;

  udsp_frame_io dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dsp_start(dsp_start),
    .io_addrW(io_addrW), .io_dataW(io_dataW), .io_writeEn(io_writeEn),
    .io_addrR(io_addrR), .io_dataR(io_dataR),
    .frame_count(frame_count)
  );

  always @(posedge clk) begin
    if (io_writeEn) mem[io_addrW] <= io_dataW;
    if (pl_en)      mem[pl_addr]  <= pl_data;
    io_dataR <= mem[io_addrR];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] base, input logic [35:0] v [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = base + 10'(i); pl_data = v[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic load(input logic [23:0] base_val, input bit chk);
    int  k = 0, guard = 0;
    bit  hs;
    @(negedge clk);
    while (k < 8 && guard < 50) begin
      in_valid = 1'b1;
      in_data  = base_val + 24'(k);
      hs = in_ready;
      @(negedge clk);
      guard++;
      if (hs) begin
        if (chk) begin
          check("wr_en",   64'(io_writeEn), 64'd1);
          check("wr_addr", 64'(io_addrW), 64'(k));
          check("wr_data", 64'(io_dataW), 64'({base_val + 24'(k), 12'h000}));
        end
        k++;
      end
      in_data = 24'hABCDEF;
    end
    if (k < 8) check("load_timeout", 64'(k), 64'd8);
    if (chk) check("in_ready_after_load", 64'(in_ready), 64'd0);
  endtask

  task automatic run_phase(input bit chk);
    int cnt = 0, viol = 0, guard = 0;
    while (dsp_start && guard < 20) begin @(negedge clk); guard++; end
    guard = 0;
    while (!dsp_start && guard < 2000) begin
      cnt++;
      if (io_writeEn) viol++;
      if (in_ready)   viol++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (chk) begin
      check("run_length", 64'(cnt), 64'd516);
      check("run_violations", 64'(viol), 64'd0);
      check("first_read_addr", 64'(io_addrR), 64'd128);
    end else if (cnt != 516) check("run_length_f", 64'(cnt), 64'd516);
  endtask

  task automatic drain(input logic [23:0] exp [8], input bit randrdy, input int stop_after,
                       output int sp);
    int n = 0, guard = 0, t0 = 0, tl = 0;
    bit prev_stall = 0, first = 1;
    logic [23:0] prev_d = '0;
    logic [9:0]  prev_a = '0;
    while (n < stop_after && guard < 200) begin
      out_ready = randrdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall) check("stall_hold", 64'(out_data), 64'(prev_d));
      if (!first && !(out_valid && out_ready)) check("addr_hold", 64'(io_addrR), 64'(prev_a));
      if (out_valid && out_ready) begin
        check("out_data", 64'(out_data), 64'(exp[n]));
        if (n < 7) check("next_read_addr", 64'(io_addrR), 64'(128 + n + 1));
        if (n == 0) t0 = guard;
        tl = guard;
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_a = io_addrR;
      first = 0;
      @(negedge clk);
      guard++;
    end
    if (n < stop_after) check("drain_timeout", 64'(n), 64'(stop_after));
    sp = tl - t0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_dsp_start", 64'(dsp_start), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_dsp_start", 64'(dsp_start), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_wr_en", 64'(io_writeEn), 64'd0);
    check("post_rst_frames", 64'(frame_count), 64'd0);

    // Frame 1: checked load, checked run window, full-rate drain.
    preload(10'd128, v1);
    load(24'h000001, 1'b1);
    run_phase(1'b1);
    drain(e1, 1'b0, 8, span);
    check("drain_consecutive", 64'(span), 64'd7);
    check("frames_1", 64'(frame_count), 64'd1);
    check("reload_in_ready", 64'(in_ready), 64'd1);
    check("drain_done_valid", 64'(out_valid), 64'd0);
    check("drain_done_start", 64'(dsp_start), 64'd1);

    // Frame 2: random backpressure on the output.
    preload(10'd128, v2);
    load(24'h100000, 1'b0);
    run_phase(1'b0);
    drain(e2, 1'b1, 8, span);
    check("frames_2", 64'(frame_count), 64'd2);
    check("mem_last_input", 64'(mem[7]), 64'h100007000);

    // Frame 3: reset after three outputs.
    load(24'h200000, 1'b0);
    run_phase(1'b0);
    drain(e2, 1'b0, 3, span);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_dsp_start", 64'(dsp_start), 64'd1);
    check("midrst_wr_en", 64'(io_writeEn), 64'd0);
    check("midrst_frames", 64'(frame_count), 64'd0);
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("midrst_reload_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
